// File: rtl/mat_pkg.sv
// mat_pkg: shared dimensions and FSM state encoding for the matrix loader
package mat_pkg;
   localparam int MAT_N = 2;
   localparam int MAT_ELEMS = MAT_N * MAT_N;
   localparam int CNT_W = $clog2(MAT_ELEMS);
   typedef enum logic [1:0] {LOAD_A, LOAD_B, FULL} state_t;
endpackage

// File: rtl/mat_loader_if.sv
// mat_loader_if: element input and matrix-pair output handshakes; keep_a exists only with MAT_LOADER_KEEP_A_EN
interface mat_loader_if
   import mat_pkg::*;
#(
   parameter int DW = 8
);
   logic [DW-1:0]           in_data;
   logic                    in_valid;
   logic                    in_ready;
   logic [MAT_ELEMS*DW-1:0] a_out;
   logic [MAT_ELEMS*DW-1:0] b_out;
   logic                    out_valid;
   logic                    out_ready;
`ifdef MAT_LOADER_KEEP_A_EN
   logic                    keep_a;
   modport master (output in_data, in_valid, out_ready, keep_a, input in_ready, a_out, b_out, out_valid);
   modport slave (input in_data, in_valid, out_ready, keep_a, output in_ready, a_out, b_out, out_valid);
`else
   modport master (output in_data, in_valid, out_ready, input in_ready, a_out, b_out, out_valid);
   modport slave (input in_data, in_valid, out_ready, output in_ready, a_out, b_out, out_valid);
`endif
endinterface

// File: rtl/mat_shift4.sv
// mat_shift4: MAT_ELEMS-deep element shift register; newest element enters the LSBs
module mat_shift4
   import mat_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en_i,
   input  logic [DW-1:0]           d_i,
   output logic [MAT_ELEMS*DW-1:0] q_o
);
   logic [MAT_ELEMS*DW-1:0] q_q;
   assign q_o = q_q;
   // shift one element in per enabled cycle, oldest element ends up in the MSBs
   always_ff @(posedge clk or posedge rst)
      if (rst) q_q <= '0;
      else if (en_i) q_q <= {q_q[(MAT_ELEMS-1)*DW-1:0], d_i};
endmodule

// File: rtl/mat_loader.sv
// mat_loader: assembles row-major 2x2 operands A then B from an element stream; MAT_LOADER_KEEP_A_EN reuses A
module mat_loader
   import mat_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic        clk,
   input  logic        rst,
   mat_loader_if.slave bus
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MAT_ELEMS - 1);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             acc, en_a, en_b, keep;
`ifdef MAT_LOADER_KEEP_A_EN
   assign keep = bus.keep_a;
`else
   assign keep = 1'b0;
`endif
   assign acc = bus.in_valid && (state_q != FULL);
   assign bus.in_ready = state_q != FULL;
   assign bus.out_valid = out_valid_q;
   // next state: count accepted elements per matrix, hold while FULL until the pair is taken
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      en_a = 1'b0;
      en_b = 1'b0;
      case (state_q)
         LOAD_A: if (acc) begin
            en_a = 1'b1;
            cnt_d = cnt_q + 1'b1;
            state_d = (cnt_q == LAST) ? LOAD_B : LOAD_A;
         end
         LOAD_B: if (acc) begin
            en_b = 1'b1;
            cnt_d = cnt_q + 1'b1;
            state_d = (cnt_q == LAST) ? FULL : LOAD_B;
         end
         FULL: if (bus.out_ready) begin
            cnt_d = '0;
            state_d = keep ? LOAD_B : LOAD_A;
         end
         default: begin
            state_d = LOAD_A;
            cnt_d = '0;
         end
      endcase
      out_valid_d = state_d == FULL;
   end
   // state, counter and registered out_valid
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= LOAD_A;
         cnt_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         out_valid_q <= out_valid_d;
      end
   mat_shift4 #(.DW(DW)) u_a (.clk(clk), .rst(rst), .en_i(en_a), .d_i(bus.in_data), .q_o(bus.a_out));
   mat_shift4 #(.DW(DW)) u_b (.clk(clk), .rst(rst), .en_i(en_b), .d_i(bus.in_data), .q_o(bus.b_out));
endmodule

// File: tb/tb_mat_loader.sv
// tb_mat_loader: randomized scoreboard bench for mat_loader (covers MAT_LOADER_KEEP_A_EN when defined)
module tb_mat_loader;
   localparam int DW = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   mat_loader_if #(.DW(DW)) bus ();
   mat_loader #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [4*DW-1:0] exp_a[$];
   logic [4*DW-1:0] exp_b[$];
   logic [DW-1:0] pend[$];
   logic [4*DW-1:0] kept_a = '0;
   bit keep_next = 1'b0;
   int hs_cyc[$];
   bit rand_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference: elements form matrices in arrival order, row-major, first element in the MSBs
   function automatic bit model_accept(input logic [DW-1:0] d);
      pend.push_back(d);
      if (keep_next && pend.size() == 4) begin
         exp_a.push_back(kept_a);
         exp_b.push_back({pend[0], pend[1], pend[2], pend[3]});
         pend.delete();
         keep_next = 1'b0;
         return 1'b1;
      end
      if (!keep_next && pend.size() == 8) begin
         exp_a.push_back({pend[0], pend[1], pend[2], pend[3]});
         exp_b.push_back({pend[4], pend[5], pend[6], pend[7]});
         pend.delete();
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_reset();
      pend.delete();
      exp_a.delete();
      exp_b.delete();
      keep_next = 1'b0;
   endtask

   // call at a falling edge; returns at a falling edge after the element was taken
   task automatic send(input logic [DW-1:0] d);
      bit done = 1'b0;
      bit full = 1'b0;
      bus.in_data = d;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 200 && !done; k++) begin
         if (bus.in_ready) begin
            full = model_accept(d);
            done = 1'b1;
         end
         @(negedge clk);
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: element %h never accepted", d);
      end else if (full) chk("out_valid_rise", 32'(bus.out_valid), 32'd1);
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic reset_check(input string tag);
      #1;
      chk({tag, "_a_out"}, bus.a_out, 32'd0);
      chk({tag, "_b_out"}, bus.b_out, 32'd0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(negedge clk);
   endtask

   task automatic take_pair();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("after_hs_out_valid", 32'(bus.out_valid), 32'd0);
      chk("after_hs_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // monitor: sample just before the rising edge and score every output handshake
   initial forever begin
      @(negedge clk);
      #4;
      if (!rst && bus.out_valid && bus.out_ready) begin
         hs_cyc.push_back(cyc);
         if (exp_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pair: a=%h b=%h with nothing expected", bus.a_out, bus.b_out);
         end else begin
            logic [4*DW-1:0] ea, eb;
            ea = exp_a.pop_front();
            eb = exp_b.pop_front();
            chk("pair_a_out", bus.a_out, ea);
            chk("pair_b_out", bus.b_out, eb);
`ifdef MAT_LOADER_KEEP_A_EN
            if (bus.keep_a) begin
               keep_next = 1'b1;
               kept_a = ea;
            end
`endif
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_data = '0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
`ifdef MAT_LOADER_KEEP_A_EN
      bus.keep_a = 1'b0;
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      reset_check("reset");
      // basic load
      for (int i = 1; i <= 8; i++) send(8'(i));
      idle(0);
      chk("basic_a_out", bus.a_out, 32'h01020304);
      chk("basic_b_out", bus.b_out, 32'h05060708);
      chk("basic_in_ready", 32'(bus.in_ready), 32'd0);
      take_pair();
      // gaps between elements
      for (int i = 1; i <= 8; i++) begin
         send(8'(i));
         idle($urandom_range(1, 3));
      end
      chk("gaps_a_out", bus.a_out, 32'h01020304);
      chk("gaps_b_out", bus.b_out, 32'h05060708);
      take_pair();
      // backpressure with a held element that must not be captured
      for (int i = 0; i < 8; i++) send(8'($urandom_range(0, 254)));
      bus.in_data = 8'hFF;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_a_out", bus.a_out, exp_a[0]);
         chk("bp_b_out", bus.b_out, exp_b[0]);
      end
      idle(0);
      take_pair();
      // mid-load reset
      for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)));
      idle(0);
      rst = 1'b1;
      #1;
      chk("rst_hold_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_hold_a_out", bus.a_out, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      reset_check("midrst");
      for (int i = 8'h11; i <= 8'h18; i++) send(8'(i));
      idle(0);
      chk("midrst_a_out", bus.a_out, 32'h11121314);
      chk("midrst_b_out", bus.b_out, 32'h15161718);
      take_pair();
      // streaming: one pair every 9 cycles
      bus.out_ready = 1'b1;
      hs_cyc.delete();
      for (int i = 0; i < 40; i++) send(8'($urandom_range(0, 255)));
      idle(3);
      chk("stream_pairs", 32'(hs_cyc.size()), 32'd5);
      for (int i = 1; i < hs_cyc.size(); i++) chk("stream_period", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd9);
      bus.out_ready = 1'b0;
`ifdef MAT_LOADER_KEEP_A_EN
      // reuse A: only four B elements for the second pair
      for (int i = 1; i <= 8; i++) send(8'(i));
      idle(0);
      bus.keep_a = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.keep_a = 1'b0;
      bus.out_ready = 1'b0;
      for (int i = 8'h0A; i <= 8'h0D; i++) send(8'(i));
      idle(0);
      chk("keep_a_out", bus.a_out, 32'h01020304);
      chk("keep_b_out", bus.b_out, 32'h0A0B0C0D);
      take_pair();
`endif
      // random gaps and random backpressure
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 160; i++) begin
               send(8'($urandom_range(0, 255)));
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            idle(0);
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(negedge clk);
               bus.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.out_ready = 1'b1;
      idle(20);
      chk("drain_left", 32'(exp_a.size()), 32'd0);
      chk("pending_left", 32'(pend.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
